// File: rtl/lif_sweep_sched.sv
// lif_sweep_sched: time-multiplexes one shared LIF update datapath across N
// neurons. Holds the membrane-state and input-current register files, sweeps
// all neurons over a req/ack handshake on each tick, and publishes the spike
// vector of every completed sweep.
module lif_sweep_sched #(
  parameter int N       = 4,
  parameter int AW      = $clog2(N),
  parameter int STATE_W = 8,
  parameter int CUR_W   = 8,
  parameter int CLR_CUR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cur_we,
  input  logic [AW-1:0]      cur_addr,
  input  logic [CUR_W-1:0]   cur_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [STATE_W-1:0] rd_state,
  output logic               lif_req,
  output logic [STATE_W-1:0] lif_state,
  output logic [CUR_W-1:0]   lif_current,
  input  logic               lif_ack,
  input  logic [STATE_W-1:0] lif_next_state,
  input  logic               lif_spike,
  output logic [N-1:0]       spikes,
  output logic               spikes_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t               fsm;
  logic [STATE_W-1:0] state_mem [N];
  logic [CUR_W-1:0]   cur_mem   [N];
  logic [N-1:0]       spk;
  logic [N-1:0]       spk_next;
  logic [AW-1:0]      idx;
  logic [AW-1:0]      idx_nxt;
  logic               hs;
  logic               last;

  // lif_req is only ever high in RUN, so a handshake implies RUN
  assign hs       = lif_req & lif_ack;
  assign last     = (idx == AW'(N - 1));
  assign idx_nxt  = idx + 1'b1;
  assign rd_state = state_mem[rd_addr];
  assign busy     = (fsm != IDLE);

  // Spike vector with the neuron being acked merged in, so the final ack can publish it directly
  always_comb begin
    spk_next      = spk;
    spk_next[idx] = lif_spike;
  end

  // Sweep controller: walks idx across all neurons and publishes the spike vector on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= IDLE;
      idx          <= '0;
      lif_req      <= 1'b0;
      lif_state    <= '0;
      lif_current  <= '0;
      spk          <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      spikes_valid <= 1'b0;
      if (tick && fsm != IDLE) overrun <= 1'b1;
      case (fsm)
        IDLE: begin
          if (tick) begin
            fsm         <= RUN;
            idx         <= '0;
            lif_req     <= 1'b1;
            lif_state   <= state_mem[0];
            lif_current <= cur_mem[0];
          end
        end
        RUN: begin
          if (hs) begin
            spk <= spk_next;
            if (last) begin
              lif_req      <= 1'b0;
              spikes       <= spk_next;
              spikes_valid <= 1'b1;
              fsm          <= DONE;
            end else begin
              idx         <= idx_nxt;
              lif_state   <= state_mem[idx_nxt];
              lif_current <= cur_mem[idx_nxt];
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Membrane state file: written back with the datapath result on each handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) state_mem[i] <= '0;
    end else if (hs) begin
      state_mem[idx] <= lif_next_state;
    end
  end

  // Current file: optional one-shot clear on ack; a host write in the same cycle takes priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cur_mem[i] <= '0;
    end else begin
      if (CLR_CUR != 0 && hs) cur_mem[idx] <= '0;
      if (cur_we) cur_mem[cur_addr] <= cur_data;
    end
  end

endmodule

// File: tb/tb_lif_sweep_sched.sv
// tb_lif_sweep_sched: randomized and directed sweeps of lif_sweep_sched
// (N=4, one-shot currents) against a behavioural neuron-array model.
module tb_lif_sweep_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       cur_we = 1'b0;
  logic [1:0] cur_addr = '0;
  logic [7:0] cur_data = '0;
  logic [1:0] rd_addr = '0;
  logic [7:0] rd_state;
  logic       lif_req;
  logic [7:0] lif_state;
  logic [7:0] lif_current;
  logic       lif_ack = 1'b0;
  logic [7:0] lif_next_state;
  logic       lif_spike;
  logic [3:0] spikes;
  logic       spikes_valid;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int latSel = 1;
  int ackCnt = 0;
  int mstate [N];
  int mcur   [N];

  lif_sweep_sched #(.N(N), .STATE_W(8), .CUR_W(8), .CLR_CUR(1)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
    .rd_addr(rd_addr), .rd_state(rd_state),
    .lif_req(lif_req), .lif_state(lif_state), .lif_current(lif_current),
    .lif_ack(lif_ack), .lif_next_state(lif_next_state), .lif_spike(lif_spike),
    .spikes(spikes), .spikes_valid(spikes_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Bench datapath: s = state + current; spike and reset to 0 at 200 or above
  always_comb begin
    int s;
    s              = int'(lif_state) + int'(lif_current);
    lif_spike      = (s >= 200);
    lif_next_state = (s >= 200) ? 8'd0 : s[7:0];
  end

  // Ack generator: latSel==1 ties ack high, otherwise ack on the latSel-th cycle of each request
  always @(negedge clk) begin
    if (latSel <= 1) begin
      lif_ack = 1'b1;
      ackCnt  = 0;
    end else if (lif_req) begin
      if (ackCnt == latSel - 1) begin
        lif_ack = 1'b1;
        ackCnt  = 0;
      end else begin
        lif_ack = 1'b0;
        ackCnt++;
      end
    end else begin
      lif_ack = 1'b0;
      ackCnt  = 0;
    end
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic writeCur(input int a, input int d);
    @(negedge clk);
    cur_we   = 1'b1;
    cur_addr = a[1:0];
    cur_data = d[7:0];
    @(negedge clk);
    cur_we = 1'b0;
    mcur[a] = d;
  endtask

  // Model one sweep over all neurons; currents are one-shot so they clear afterwards
  task automatic modelSweep(output int sp);
    sp = 0;
    for (int i = 0; i < N; i++) begin
      int s;
      s = mstate[i] + mcur[i];
      if (s >= 200) begin
        sp |= (1 << i);
        mstate[i] = 0;
      end else begin
        mstate[i] = s;
      end
      mcur[i] = 0;
    end
  endtask

  task automatic checkStates(input string tag);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rd_addr = i[1:0];
      #1 checkOutput($sformatf("%s_state%0d", tag, i), int'(rd_state), mstate[i]);
    end
  endtask

  // Run one sweep with the given ack latency; optionally hammer a write to colAddr while it is pending
  task automatic applyStimulus(input string tag, input int lat, input int colAddr, input int colVal);
    int preS [N];
    int preC [N];
    int expSp, k, c, svCycle, reqCycles, prevS, prevC;
    logic r, a;
    latSel = lat;
    for (int i = 0; i < N; i++) begin
      preS[i] = mstate[i];
      preC[i] = mcur[i];
    end
    modelSweep(expSp);
    if (colAddr >= 0) mcur[colAddr] = colVal;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    k = 0; c = 1; svCycle = -1; reqCycles = 0; prevS = -1; prevC = -1;
    while (c < 100 && svCycle < 0) begin
      if (lif_req && k < N) begin
        reqCycles++;
        if (int'(lif_state) != prevS || int'(lif_current) != prevC) begin
          checkOutput($sformatf("%s_opstate%0d", tag, k), int'(lif_state), preS[k]);
          checkOutput($sformatf("%s_opcur%0d", tag, k), int'(lif_current), preC[k]);
        end else if (lat > 1) begin
          checkOutput($sformatf("%s_hold%0d", tag, k), int'(lif_current), preC[k]);
        end
        prevS = int'(lif_state);
        prevC = int'(lif_current);
      end
      if (spikes_valid) begin
        svCycle = c;
        checkOutput({tag, "_spikes"}, int'(spikes), expSp);
      end
      @(negedge clk);
      cur_we   = (colAddr >= 0) && lif_req && (k == colAddr);
      cur_addr = colAddr[1:0];
      cur_data = colVal[7:0];
      #1 a = lif_ack;
      r = lif_req;
      @(posedge clk);
      #1 if (r && a) begin
        k++;
        prevS = -1;
      end
      c++;
    end
    cur_we = 1'b0;
    checkOutput({tag, "_svcycle"}, svCycle, N * lat + 1);
    checkOutput({tag, "_reqcycles"}, reqCycles, N * lat);
    @(posedge clk);
    #1 checkOutput({tag, "_busyend"}, int'(busy), 0);
    checkStates(tag);
  endtask

  initial begin
    int sp, svCount;
    for (int i = 0; i < N; i++) begin
      mstate[i] = 0;
      mcur[i]   = 0;
    end
    #2 rst = 1'b1;
    #1 checkOutput("rst_req", int'(lif_req), 0);
    checkOutput("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    checkStates("rst0");

    // Basic sweeps
    writeCur(0, 10); writeCur(1, 20); writeCur(2, 30); writeCur(3, 40);
    applyStimulus("basic1", 1, -1, 0);
    writeCur(0, 10); writeCur(1, 20); writeCur(2, 30); writeCur(3, 40);
    applyStimulus("basic2", 1, -1, 0);
    checkOutput("basic2_s3", mstate[3], 80);

    // Spike on neuron 2
    writeCur(2, 250);
    applyStimulus("spike", 1, -1, 0);

    // Overrun: ticks at t, t+2, t+5
    latSel = 1;
    writeCur(1, 7);
    modelSweep(sp);
    @(negedge clk) tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    svCount = 0;
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("ovr_flag_c%0d", c), int'(overrun), (c >= 3) ? 1 : 0);
      if (spikes_valid) begin
        svCount++;
        checkOutput("ovr_svcycle", c, 5);
      end
      @(negedge clk) tick = (c == 2 || c == 5);
      @(posedge clk);
      #1;
    end
    tick = 1'b0;
    checkOutput("ovr_svcount", svCount, 1);
    checkOutput("ovr_idle", int'(busy), 0);
    checkStates("ovr");

    // Reset mid-sweep
    writeCur(0, 33);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 checkOutput("rstmid_req", int'(lif_req), 0);
    checkOutput("rstmid_ovr", int'(overrun), 0);
    checkOutput("rstmid_spk", int'(spikes), 0);
    checkOutput("rstmid_op", int'(lif_state) + int'(lif_current), 0);
    checkOutput("rstmid_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      mstate[i] = 0;
      mcur[i]   = 0;
    end
    checkStates("rstmid");
    applyStimulus("afterrst", 1, -1, 0);

    // Backpressure: ack on the third cycle of each request
    writeCur(0, 10); writeCur(1, 20); writeCur(2, 30); writeCur(3, 40);
    applyStimulus("bp", 3, -1, 0);

    // Write collision with the pending neuron under one-shot clearing
    writeCur(1, 5);
    applyStimulus("col", 3, 1, 99);
    applyStimulus("colnext", 1, -1, 0);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) writeCur(i, int'($urandom_range(0, 150)));
      applyStimulus($sformatf("rnd%0d", r), int'($urandom_range(1, 3)), -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_sweep_sched.md
# lif_sweep_sched

Time-multiplexing controller that shares one LIF neuron update datapath across `N` logical neurons. It owns the per-neuron membrane-state and input-current register files. On each `tick` it sweeps every neuron through the shared datapath over a req/ack handshake, writes back the next state, and publishes the sweep's spike vector. It sits between the host-side current/tick interface and the single `lif` instance in the top level.

## Interface

Parameters:
- `N` — default 4 — neuron count; power of two, ≥2.
- `AW` — default `$clog2(N)` — neuron address width.
- `STATE_W` — default 8 — membrane state width.
- `CUR_W` — default 8 — input current width.
- `CLR_CUR` — default 0 — 1: clear a neuron's current register after its update is acked (one-shot input).

Ports:
- `clk` — in — 1 — single clock; all state on rising edge.
- `rst` — in — 1 — asynchronous, active-high reset.
- `tick` — in — 1 — start a sweep; honoured only in IDLE.
- `cur_we` — in — 1 — write enable for a current register.
- `cur_addr` — in — AW — neuron index for the write.
- `cur_data` — in — CUR_W — current value to write.
- `rd_addr` — in — AW — state readback index.
- `rd_state` — out — STATE_W — combinational `state[rd_addr]`.
- `lif_req` — out — 1 — operands valid to the shared datapath.
- `lif_state` — out — STATE_W — registered operand: state of the neuron being updated.
- `lif_current` — out — CUR_W — registered operand: current of the neuron being updated.
- `lif_ack` — in — 1 — datapath result valid this cycle.
- `lif_next_state` — in — STATE_W — updated state; sampled when `lif_req & lif_ack`.
- `lif_spike` — in — 1 — spike flag; sampled with `lif_next_state`.
- `spikes` — out — N — spike vector of the last completed sweep; bit i is neuron i.
- `spikes_valid` — out — 1 — one-cycle pulse when `spikes` updates.
- `busy` — out — 1 — high whenever the FSM is not in IDLE.
- `overrun` — out — 1 — sticky flag: a tick arrived while busy.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `tick`. Sets `idx=0`, loads `lif_state`/`lif_current` from entry 0, asserts `lif_req`.
  - RUN, `lif_ack` with `idx<N-1`:
    - write `state[idx] <= lif_next_state` and `spk[idx] <= lif_spike`;
    - apply the current clear if `CLR_CUR`;
    - `idx++`; load the operands of the new idx; `lif_req` stays high.
  - RUN, `lif_ack` with `idx==N-1`: same writeback, drop `lif_req`, go to DONE.
  - DONE → IDLE unconditionally. In DONE: `spikes <= spk`, `spikes_valid=1`.
- While `lif_req & !lif_ack`, the operand registers and `idx` hold stable.
- `lif_ack` while `lif_req=0` is ignored.
- Current writes are accepted in every state, every cycle.
  - A write to the neuron whose request is pending does not change `lif_current`; the new value applies on the next sweep.
  - With `CLR_CUR=1`, a write and a clear to the same entry in the same cycle: the write wins.
- A `tick` in RUN or DONE is dropped and sets `overrun=1`. `overrun` is cleared only by `rst`.
- A `tick` in the same cycle as DONE → IDLE is dropped, counted as overrun.
- Reset values, all applied immediately and asynchronously:
  - every `state[i]`, `cur[i]`, `spk`, `spikes`, `lif_state`, `lif_current` = 0;
  - `lif_req`, `spikes_valid`, `busy`, `overrun` = 0;
  - FSM = IDLE, `idx` = 0.
- Reset mid-sweep aborts it: no `spikes_valid`, and partial writebacks are discarded by the reset itself.

## Timing

- Tick sampled at cycle t:
  - `lif_req` and operands valid from t+1;
  - `busy` high from t+1 through DONE.
- With `lif_ack` tied high:
  - one neuron per cycle, `lif_req` high t+1..t+N;
  - DONE and `spikes_valid` at t+N+1;
  - a new tick is accepted at t+N+2 or later.
- With k cycles of req-to-ack latency per neuron, `spikes_valid` occurs at t+N·k+1.
- `rd_state` reflects a writeback the cycle after the ack edge.

## Test plan

Bench datapath model: `s = state + current`; if `s ≥ 200` then spike=1 and next=0, else spike=0 and next=s.

- **Reset:** assert `rst` mid-run. All outputs go to 0 asynchronously; `rd_state`=0 for every address after release.
- **Basic sweeps:** N=4, ack tied 1, currents 10/20/30/40, tick at t.
  - `lif_req` t+1..t+4; `spikes_valid` at t+5 with `spikes`=0000; states read 10/20/30/40.
  - Second tick: states 20/40/60/80.
- **Spike:** `cur[2]=250`, tick → `spikes`=4'b0100, `state[2]`=0, others unchanged.
- **Backpressure:** ack on the 3rd cycle of each request.
  - Operands stable across each wait.
  - `spikes_valid` at t+13; results identical to the tied-ack run.
- **Overrun:** tick at t, t+2, and t+5 (N=4, ack=1).
  - Exactly one `spikes_valid`, at t+5.
  - `overrun`=1 from t+3 and stays 1 until `rst`.
- **Write collision:** CLR_CUR=1; write `cur[1]=99` while neuron 1's request is pending with old value 5.
  - Datapath receives 5.
  - Afterwards `cur[1]`=99: the write beat the clear.
  - Next sweep uses 99.
